// File: rtl/odd_parity_frame_tx.sv
// Two-requester round-robin serial frame transmitter: start, 4 data bits LSB first,
// odd-parity bit, stop. One shared nibble shift register and parity generator.
module odd_parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [3:0]  shift;
  logic        parity;
  logic [1:0]  bit_idx;
  logic        last_grant;

  logic        winner;
  logic        accept;
  logic [3:0]  win_data;
  logic        bit_end;

  // Contention goes to whoever did not win last; a lone valid always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign win_data   = winner ? req1_data : req0_data;
  assign req0_ready = (state == IDLE) && !winner && req0_valid;
  assign req1_ready = (state == IDLE) &&  winner && req1_valid;
  assign bit_end    = (cnt == 16'd0);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      bit_idx    <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      tx         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            shift      <= win_data;
            parity     <= ~^win_data;
            grant_id   <= winner;
            last_grant <= winner;
            cnt        <= BIT_RELOAD;
            bit_idx    <= '0;
            tx         <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= BIT_RELOAD;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= BIT_RELOAD;
            shift <= {1'b0, shift[3:1]};
            if (bit_idx == 2'd3) begin
              tx    <= parity;
              state <= PARITY;
            end else begin
              // tx is registered, so it takes the bit that lands in shift[0] after this shift.
              tx      <= shift[1];
              bit_idx <= bit_idx + 2'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt   <= BIT_RELOAD;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Scoreboard bench for odd_parity_frame_tx: a cycle-level reference model predicts
// arbitration and handshake, and a line monitor decodes frames off tx against a queue.
module tb_odd_parity_frame_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 7 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic       req0_ready, req1_ready, tx, busy, grant_id, frame_done;

  odd_parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] data;
    logic       par;
  } exp_t;

  exp_t        expq[$];
  logic [3:0]  pend0[$], pend1[$];
  logic        glog[$];
  int          total = 0, bad = 0;
  bit          sync_mode = 1'b1;
  bit          acc0 = 1'b0, acc1 = 1'b0;

  int          mdl_rem = 0;
  logic        mdl_last = 1'b1;
  logic        mdl_gid = 1'b0;

  logic        samp [0:FRAME-1];
  int          nsamp = 0;
  bit          collecting = 1'b0, need_idle = 1'b0;
  logic        gid_s;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic odd_par(input logic [3:0] w);
    int ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(w[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Driver, then (after inputs settle) the reference model for the same cycle.
  always @(negedge clk) begin
    logic w, e0, e1;
    if (rst) begin
      v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      if (acc0) begin v0 = 1'b0; pend0.delete(0); end
      if (acc1) begin v1 = 1'b0; pend1.delete(0); end
      if (!v0) begin
        if (pend0.size() > 0 && (sync_mode || $urandom_range(1, 0) == 1)) begin
          v0 = 1'b1; d0 = pend0[0];
        end else d0 = 4'($urandom);
      end
      if (!v1) begin
        if (pend1.size() > 0 && (sync_mode || $urandom_range(1, 0) == 1)) begin
          v1 = 1'b1; d1 = pend1[0];
        end else d1 = 4'($urandom);
      end
    end
    #1;
    acc0 = v0 && req0_ready;
    acc1 = v1 && req1_ready;
    if (rst) begin
      mdl_rem = 0; mdl_last = 1'b1; mdl_gid = 1'b0;
      expq.delete();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_grant_id", grant_id, 0);
    end else if (mdl_rem > 0) begin
      chk("frame_busy", busy, 1);
      chk("frame_ready0", req0_ready, 0);
      chk("frame_ready1", req1_ready, 0);
      chk("frame_done", frame_done, (mdl_rem == 1) ? 1 : 0);
      chk("frame_grant_id", grant_id, mdl_gid);
      mdl_rem--;
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_frame_done", frame_done, 0);
      chk("idle_tx", tx, 1);
      chk("idle_grant_id", grant_id, mdl_gid);
      w  = (v0 && v1) ? !mdl_last : v1;
      e0 = v0 && !w;
      e1 = v1 && w;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      if (v0 || v1) begin
        mdl_last = w;
        mdl_gid  = w;
        mdl_rem  = FRAME;
        expq.push_back('{id: w, data: (w ? d1 : d0), par: odd_par(w ? d1 : d0)});
      end
    end
  end

  // Line monitor: decodes each frame from tx alone.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      collecting = 1'b0; nsamp = 0; need_idle = 1'b0;
    end else begin
      if (need_idle) begin
        chk("gap_idle_high", tx, 1);
        need_idle = 1'b0;
      end else if (!collecting && tx == 1'b0) begin
        collecting = 1'b1; nsamp = 0;
      end
      if (collecting) begin
        samp[nsamp] = tx;
        gid_s = grant_id;
        nsamp++;
        if (nsamp == FRAME) begin
          logic [6:0] bits;
          bit stable;
          exp_t e;
          stable = 1'b1;
          for (int b = 0; b < 7; b++) begin
            bits[b] = samp[b*CPB];
            for (int s = 1; s < CPB; s++)
              if (samp[b*CPB+s] !== bits[b]) stable = 1'b0;
          end
          chk("bit_stable", stable, 1);
          if (expq.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("start_bit", bits[0], 0);
            chk("data_bits", bits[4:1], e.data);
            chk("parity_bit", bits[5], e.par);
            chk("stop_bit", bits[6], 1);
            chk("frame_grant", gid_s, e.id);
          end
          glog.push_back(gid_s);
          collecting = 1'b0;
          need_idle  = 1'b1;
        end
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #3;
      done = pend0.size() == 0 && pend1.size() == 0 && !v0 && !v1 &&
             mdl_rem == 0 && expq.size() == 0 && !collecting && !need_idle;
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic wait_rem(input int val);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #2;
      hit = (mdl_rem == val);
    end
    chk("wait_rem_timeout", hit, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    repeat (50) @(negedge clk);

    pend0.push_back(4'b0000);
    drain();
    pend1.push_back(4'b1011);
    drain();

    glog.delete();
    pend0.push_back(4'b0101); pend0.push_back(4'b0101);
    pend1.push_back(4'b1010); pend1.push_back(4'b1010);
    drain();
    chk("rr_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("rr_grant0", glog[0], 0);
      chk("rr_grant1", glog[1], 1);
      chk("rr_grant2", glog[2], 0);
      chk("rr_grant3", glog[3], 1);
    end

    pend0.push_back(4'b0011);
    wait_rem(14);
    #1;
    chk("pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #3;
    glog.delete();
    pend0.push_back(4'hC); pend1.push_back(4'h7);
    rst = 1'b0;
    drain();
    chk("post_rst_count", glog.size(), 2);
    if (glog.size() > 0) chk("post_rst_first_grant", glog[0], 0);

    pend0.push_back(4'h6);
    wait_rem(10);
    pend1.push_back(4'h9);
    drain();

    sync_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) pend0.push_back(4'($urandom));
      else pend1.push_back(4'($urandom));
    end
    drain();
    chk("leftover_expected", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
